// File: rtl/projrouter_pkg.sv
// projrouter_pkg: shared widths, scan states and VM region helper for
// projection_router_gen (optional feature macro PROJROUTER_DROP_CNT_EN).
package projrouter_pkg;
  localparam int TAG_W    = 4;
  localparam int IDX_W    = 6;
  localparam int PAGE_W   = 4;
  localparam int VMPROJ_W = 13;
  localparam int CH_W     = TAG_W - 1;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  // Two phi codes share one VM region after the odd-sector shift.
  function automatic logic [2:0] vm_region(
    input logic [2:0] f,
    input logic       odd,
    input int         n_phi
  );
    logic [2:0] r;
    r = (f - {2'b00, odd}) >> 1;
    if (int'(r) > n_phi - 1) r = 3'(n_phi - 1);
    return r;
  endfunction
endpackage

// File: rtl/projrouter_vm_decode.sv
// projrouter_vm_decode: phi/r fields to one-hot VM write enable and the
// packed VM projection word, registered.
module projrouter_vm_decode
  import projrouter_pkg::*;
#(
  parameter int N_PHI = 4,
  parameter int N_R   = 2,
  parameter int ODD   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [2:0]             i_f,
  input  logic [3:0]             i_z,
  input  logic                   i_row,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [VMPROJ_W-1:0]    o_vmproj,
  output logic [N_PHI*N_R-1:0]   o_wr_en
);
  localparam int EN_W = N_PHI * N_R;

  logic [2:0]      w_reg;
  int              w_sh;
  logic [EN_W-1:0] w_en;

  always_comb begin
    w_reg = vm_region(i_f, 1'(ODD), N_PHI);
    w_sh  = int'(w_reg);
    if (N_R == 2 && i_row) w_sh = N_PHI + int'(w_reg);
    w_en  = '0;
    if (int'(i_f) >= ODD) w_en = EN_W'(1) << w_sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_vmproj <= '0;
      o_wr_en  <= '0;
    end else begin
      o_wr_en <= i_valid ? w_en : '0;
      if (i_valid)
        o_vmproj <= {i_idx, i_f[2] ^ 1'(ODD), i_f[1:0], i_z};
    end
  end
endmodule

// File: rtl/projection_router_gen.sv
// projection_router_gen: priority merge of N_IN projection memories into a
// tagged stream plus VM routing; PROJROUTER_DROP_CNT_EN adds drop_cnt.
module projection_router_gen
  import projrouter_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int PROJ_W  = 54,
  parameter int N_PHI   = 4,
  parameter int N_R     = 2,
  parameter int ODD     = 1,
  parameter int PHI_LSB = 38,
  parameter int R_BIT   = 24,
  parameter int Z_LSB   = 20,
  parameter int RD_LAT  = 2,
  parameter int N_HOLD  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     done,
  input  logic [N_IN*6-1:0]        number_in,
  output logic [N_IN*10-1:0]       read_add,
  input  logic [N_IN*PROJ_W-1:0]   proj_in,
  output logic [PROJ_W+3:0]        allprojout,
  output logic                     allproj_wr_en,
  output logic [VMPROJ_W-1:0]      vmprojout,
  output logic [N_PHI*N_R-1:0]     vmproj_wr_en,
  output logic                     index_ovf
`ifdef PROJROUTER_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_t                       r_state, w_state_nx;
  logic [PAGE_W-1:0]            r_page;
  logic [N_IN-1:0][IDX_W-1:0]   r_ptr, r_num;
  logic [N_IN-1:0][9:0]         r_read_add;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_ovf;
  logic [N_HOLD:0]              r_dsh;
  logic [RD_LAT-1:0]            r_pv;
  logic [RD_LAT-1:0][CH_W-1:0]  r_pc;
  logic [RD_LAT-1:0][IDX_W-1:0] r_pi;
  logic [TAG_W+PROJ_W-1:0]      r_all;
  logic                         r_all_en;
  logic                         w_any, w_issue;
  logic [CH_W-1:0]              w_sel, w_oc;
  logic [PROJ_W-1:0]            w_proj;

  assign read_add      = r_read_add;
  assign index_ovf     = r_ovf;
  assign done          = r_dsh[N_HOLD];
  assign allprojout    = r_all;
  assign allproj_wr_en = r_all_en;

  // Ascending scan: the last hit is the highest-priority channel.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int c = 0; c < N_IN; c++)
      if (r_ptr[c] < r_num[c]) begin
        w_any = 1'b1;
        w_sel = CH_W'(c);
      end
  end

  assign w_issue = (r_state == S_SCAN) && w_any && !start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (start)
      w_state_nx = S_SCAN;
    else if (r_state == S_SCAN && !w_any)
      w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_page <= '1;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
      for (int c = 0; c < N_IN; c++) begin
        r_ptr[c]      <= '0;
        r_num[c]      <= '0;
        r_read_add[c] <= {4'hF, 6'h0};
      end
    end else if (start) begin
      r_page <= r_page + 4'd1;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
      for (int c = 0; c < N_IN; c++) begin
        r_ptr[c] <= '0;
        r_num[c] <= number_in[6*c +: 6];
      end
    end else if (w_issue) begin
      for (int c = 0; c < N_IN; c++)
        if (w_sel == CH_W'(c)) begin
          r_read_add[c] <= {r_page, r_ptr[c]};
          r_ptr[c]      <= r_ptr[c] + 6'd1;
        end
      if (r_idx == IDX_MAX) r_ovf <= 1'b1;
      else                  r_idx <= r_idx + 6'd1;
    end
  end

  // Tag pipe tracks each read until its data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= '0;
      r_pc <= '0;
      r_pi <= '0;
    end else begin
      r_pv[0] <= w_issue && (r_idx != IDX_MAX);
      r_pc[0] <= w_sel;
      r_pi[0] <= r_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pc[k] <= r_pc[k-1];
        r_pi[k] <= r_pi[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_dsh <= '0;
    else       r_dsh <= (r_dsh << 1) | (N_HOLD+1)'(start);
  end

  assign w_oc = r_pc[RD_LAT-1];

  always_comb begin
    w_proj = '0;
    for (int c = 0; c < N_IN; c++)
      if (w_oc == CH_W'(c)) w_proj = proj_in[c*PROJ_W +: PROJ_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_all    <= '0;
      r_all_en <= 1'b0;
    end else begin
      r_all_en <= r_pv[RD_LAT-1];
      if (r_pv[RD_LAT-1])
        r_all <= {{1'b0, w_oc} + 4'd1, w_proj};
    end
  end

  projrouter_vm_decode #(
    .N_PHI (N_PHI),
    .N_R   (N_R),
    .ODD   (ODD)
  ) u_vm_decode (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (r_pv[RD_LAT-1]),
    .i_f      (w_proj[PHI_LSB +: 3]),
    .i_z      (w_proj[Z_LSB +: 4]),
    .i_row    ((N_R == 2) ? w_proj[R_BIT] : 1'b0),
    .i_idx    (r_pi[RD_LAT-1]),
    .o_vmproj (vmprojout),
    .o_wr_en  (vmproj_wr_en)
  );

`ifdef PROJROUTER_DROP_CNT_EN
  logic [7:0] r_drop;

  always_ff @(posedge clk) begin
    if (reset || start)
      r_drop <= '0;
    else if (w_issue && r_idx == IDX_MAX && r_drop != 8'hFF)
      r_drop <= r_drop + 8'd1;
  end

  assign drop_cnt = r_drop;
`endif
endmodule

// File: tb/tb_projection_router_gen.sv
// tb_projection_router_gen: random events against a queue-based
// reference model of the router; scoreboard monitor checks every write.
module tb_projection_router_gen;
  localparam int N_IN    = 3;
  localparam int PW      = 54;
  localparam int N_PHI   = 4;
  localparam int N_R     = 2;
  localparam int ODD     = 1;
  localparam int PHI_LSB = 38;
  localparam int R_BIT   = 24;
  localparam int Z_LSB   = 20;
  localparam int RD_LAT  = 2;
  localparam int N_HOLD  = 3;
  localparam int EN_W    = N_PHI * N_R;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  done;
  logic [N_IN*6-1:0]     number_in = '0;
  logic [N_IN*10-1:0]    read_add;
  logic [N_IN*PW-1:0]    proj_in;
  logic [PW+3:0]         allprojout;
  logic                  allproj_wr_en;
  logic [12:0]           vmprojout;
  logic [EN_W-1:0]       vmproj_wr_en;
  logic                  index_ovf;
`ifdef PROJROUTER_DROP_CNT_EN
  logic [7:0]            drop_cnt;
`endif

  projection_router_gen #(
    .N_IN(N_IN), .PROJ_W(PW), .N_PHI(N_PHI), .N_R(N_R), .ODD(ODD),
    .PHI_LSB(PHI_LSB), .R_BIT(R_BIT), .Z_LSB(Z_LSB),
    .RD_LAT(RD_LAT), .N_HOLD(N_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .number_in(number_in), .read_add(read_add), .proj_in(proj_in),
    .allprojout(allprojout), .allproj_wr_en(allproj_wr_en),
    .vmprojout(vmprojout), .vmproj_wr_en(vmproj_wr_en),
    .index_ovf(index_ovf)
`ifdef PROJROUTER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories with RD_LAT-cycle read latency.
  logic [PW-1:0]      mem [N_IN][1024];
  logic [N_IN*10-1:0] ra_q [RD_LAT];
  logic [N_IN*10-1:0] ra_sel;

  always @(posedge clk) begin
    ra_q[0] <= read_add;
    for (int k = 1; k < RD_LAT; k++) ra_q[k] <= ra_q[k-1];
  end

  assign ra_sel = (RD_LAT == 1) ? read_add : ra_q[(RD_LAT > 1) ? RD_LAT-2 : 0];

  always_comb begin
    proj_in = '0;
    for (int c = 0; c < N_IN; c++)
      proj_in[c*PW +: PW] = mem[c][ra_sel[c*10 +: 10]];
  end

  typedef struct {
    logic [PW+3:0]   all;
    logic [12:0]     vm;
    logic [EN_W-1:0] en;
    int              cyc;
  } exp_t;

  exp_t       exp_q[$];
  bit         st[int];
  int         total = 0;
  int         bad = 0;
  int         exp_total = 0;
  logic [3:0] page_m = 4'hF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trunc(input int lim);
    exp_t tmp[$];
    foreach (exp_q[i]) if (exp_q[i].cyc <= lim) tmp.push_back(exp_q[i]);
    exp_q = tmp;
  endtask

  task automatic push_exp(input int c, input logic [9:0] a, input int k, input int oc);
    exp_t e;
    logic [PW-1:0] p;
    int f, rg, row;
    p = mem[c][a];
    f = int'(p[PHI_LSB +: 3]);
    e.all = {4'(c + 1), p};
    e.vm  = {6'(k), 1'(f >> 2) ^ 1'(ODD), 2'(f), p[Z_LSB +: 4]};
    e.en  = '0;
    if (f >= ODD) begin
      rg = (f - ODD) / 2;
      if (rg > N_PHI - 1) rg = N_PHI - 1;
      row = (N_R == 2) ? int'(p[R_BIT]) : 0;
      e.en[row*N_PHI + rg] = 1'b1;
    end
    e.cyc = oc;
    exp_q.push_back(e);
  endtask

  // Entry k of an event started in cycle s emerges in cycle s+k+RD_LAT+2.
  task automatic do_start(input logic [N_IN*6-1:0] nums);
    int s, k;
    s = cyc;
    trunc(s + RD_LAT);
    page_m = page_m + 4'd1;
    st[s] = 1'b1;
    k = 0;
    for (int c = N_IN - 1; c >= 0; c--)
      for (int p = 0; p < int'(nums[c*6 +: 6]); p++) begin
        if (k < 63) push_exp(c, {page_m, 6'(p)}, k, s + k + RD_LAT + 2);
        k++;
      end
    exp_total = k;
    start = 1'b1;
    number_in = nums;
    tick();
    start = 1'b0;
  endtask

  task automatic end_event();
    repeat (exp_total + RD_LAT + 4) tick();
    chk("index_ovf", index_ovf, exp_total > 63);
`ifdef PROJROUTER_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, (exp_total > 63) ? exp_total - 63 : 0);
`endif
  endtask

  task automatic check_reset_state();
    logic [N_IN*10-1:0] ra_exp;
    for (int c = 0; c < N_IN; c++) ra_exp[c*10 +: 10] = 10'h3C0;
    chk("rst_read_add", read_add, ra_exp);
    chk("rst_allproj_wr_en", allproj_wr_en, 0);
    chk("rst_vmproj_wr_en", vmproj_wr_en, 0);
    chk("rst_index_ovf", index_ovf, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin : monitor
    exp_t e;
    bit   exp_done;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_write actual=none required_cycle=%0d", e.cyc);
      end
      if (allproj_wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_write", allproj_wr_en, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("allprojout", allprojout, e.all);
          chk("vmprojout", vmprojout, e.vm);
          chk("vmproj_wr_en", vmproj_wr_en, e.en);
        end
      end else begin
        chk("vm_en_idle", vmproj_wr_en, 0);
      end
      exp_done = st.exists(cyc - N_HOLD - 1);
      if (done || exp_done) chk("done", done, exp_done);
    end
  end

  initial begin : stim
    logic [N_IN*6-1:0] nums;
    int r;
    for (int c = 0; c < N_IN; c++)
      for (int a = 0; a < 1024; a++)
        mem[c][a] = PW'({$urandom(), $urandom()});

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    tick();

    // counts {ch0=3, ch1=0, ch2=2}
    do_start({6'd2, 6'd0, 6'd3});
    end_event();
    chk("ra_ch2_last", read_add[20 +: 10], 10'h001);
    chk("ra_ch0_last", read_add[0 +: 10], 10'h002);
    chk("ra_ch1_unread", read_add[10 +: 10], 10'h3C0);

    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < N_IN; c++) nums[c*6 +: 6] = 6'($urandom_range(0, 20));
      do_start(nums);
      end_event();
    end

    do_start({6'd0, 6'd40, 6'd40});
    end_event();

    for (int c = 0; c < N_IN; c++) nums[c*6 +: 6] = 6'($urandom_range(15, 63));
    do_start(nums);
    end_event();

    // new start after 4 issues of the previous event
    do_start({6'd8, 6'd5, 6'd10});
    repeat (4) tick();
    for (int c = 0; c < N_IN; c++) nums[c*6 +: 6] = 6'($urandom_range(1, 12));
    do_start(nums);
    end_event();

    // reset during a scan
    do_start({6'd20, 6'd20, 6'd20});
    repeat (5) tick();
    r = cyc;
    reset = 1'b1;
    trunc(r);
    st.delete();
    page_m = 4'hF;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    tick();
    for (int c = 0; c < N_IN; c++) nums[c*6 +: 6] = 6'($urandom_range(1, 12));
    do_start(nums);
    end_event();

    repeat (10) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/projection_router_gen.md
# projection_router_gen

Parametrised successor of the disk projection router. Reads up to `N_IN` tracklet-projection memories page-by-page each event, merges them in fixed priority order into one all-projection stream tagged with its source channel, and routes a compact VM projection word to one of `N_PHI × N_R` VM projection memories. Assigns a dense per-event output index, ends each channel's scan exactly at its entry count, and survives a new `start` arriving mid-scan.

## Interface
- `N_IN`, 3: number of input projection memories (1–8); channel `N_IN-1` has highest priority.
- `PROJ_W`, 54: projection word width.
- `N_PHI`, 4: VM phi regions (power of 2).
- `N_R`, 2: VM r/z regions (1 or 2).
- `ODD`, 1: odd-sector phi offset (0/1).
- `PHI_LSB`, 38: LSB of the 3-bit phi field in the projection word.
- `R_BIT`, 24: bit selecting the r region (ignored when `N_R`=1).
- `Z_LSB`, 20: LSB of the 4-bit fine-z field.
- `RD_LAT`, 2: input memory read latency in cycles (1–3).
- `N_HOLD`, 3: `done` delay after `start`.
- `clk` in 1: processing clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse, new event.
- `done` out 1: pulse `N_HOLD+1` cycles after `start`.
- `number_in` in `N_IN*6`: per-channel entry count, channel c at `[6c+:6]`.
- `read_add` out `N_IN*10`: per-channel read address `{page[3:0], ptr[5:0]}`.
- `proj_in` in `N_IN*PROJ_W`: per-channel read data.
- `allprojout` out `PROJ_W+4`: `{tag[3:0], projection}`, tag = channel+1.
- `allproj_wr_en` out 1: `allprojout` valid.
- `vmprojout` out 13: `{index[5:0], phi_hi^ODD, phi[1:0], z[3:0]}`.
- `vmproj_wr_en` out `N_PHI*N_R`: one-hot write enable, bit `r*N_PHI + phi_region`.
- `index_ovf` out 1: sticky per event; an entry was dropped because index reached 63.

## Operation
- Reset: `page`=4'hF, all pointers 0, `read_add`={4'hF,6'h0}, state IDLE, all outputs and enables 0, index 0, pipeline valid bits cleared.
- States: IDLE, SCAN.
- `start` (any state): `page`←`page+1`, pointers←0, `number_in` latched per channel, index←0, `index_ovf`←0, state←SCAN. In-flight reads from the previous event complete normally with their captured tags and indices.
- SCAN, each cycle: select the highest channel c with `ptr[c] < num_lat[c]`. Drive `read_add[c]`={page,ptr[c]}, increment `ptr[c]`, push {valid, c, index} into a `RD_LAT`-deep tag pipe, increment index. Non-selected channels hold their addresses.
- No channel remaining → IDLE, issue nothing.
- Index at 63 with entries remaining: issue continues, pipe valid=0, `index_ovf`←1.
- Zero-count channels are never read.
- Output stage, on pipe valid: `allprojout`←{c+1, proj_in[c]}, `allproj_wr_en`←1. Phi field f=proj[PHI_LSB+:3]. If f<ODD, no VM enable. Otherwise region=min((f−ODD)>>1, N_PHI−1), row=proj[R_BIT] (0 if `N_R`=1), set one enable bit. `vmprojout` carries the pipe index.
- `done`: a `start` shift register only, independent of scan progress.

## Timing
- `read_add` registered: issue in cycle t.
- `proj_in` sampled at t+`RD_LAT`.
- `allprojout`, `allproj_wr_en`, `vmprojout`, `vmproj_wr_en` valid at t+`RD_LAT`+1, held one cycle.
- Sustained throughput: one projection per cycle.
- First issue occurs the cycle after `start`.
- Total issue cycles per event = min(Σ`num_lat`, 64+drops).
- `start` and `reset` together: reset wins.

## Configuration
- `PROJROUTER_DROP_CNT_EN` defined: adds output `drop_cnt[7:0]`, the count of entries dropped by index overflow in the current event. It saturates at 255, clears on `start`, and is 0 at reset.
- Undefined: port and counter absent. `index_ovf` is unaffected either way.

## Structure
- Package `projrouter_pkg`: `TAG_W`=4, `IDX_W`=6, `PAGE_W`=4, `VMPROJ_W`=13, and the function `vm_region(f, odd, n_phi)`.
- One sub-module, `projrouter_vm_decode`: combinational phi/r decode to one-hot enable plus `vmprojout` packing, with a registered output.
- Priority select and tag pipe stay in the top module.

## Test plan
- Defaults, counts {3,0,2}: 5 issues in order ch2 p0,p1, ch0 p0,p1,p2. Tags 3,3,1,1,1. Indices 0–4. First `allproj_wr_en` 3 cycles after first issue.
- Phi sweep, ODD=1: f=0 gives no enable; f=1,2 → bit0; f=7 → bit3. `R_BIT`=1 with f=3 → bit5.
- Counts {40,40,0}: 63 writes, then `index_ovf`=1 with 17 drops; `drop_cnt`=17 when the macro is enabled.
- `start` mid-scan after 4 issues: page increments, pointers restart at 0, the 2 in-flight results still emerge with old indices, new indices restart at 0.
- `reset` asserted during SCAN: next cycle all enables 0 and `read_add`={F,0}; next `start` uses page 0.
- N_IN=5, RD_LAT=1, counts all 1: ch4..ch0 are read in order, each output 2 cycles after its issue.
